// File: rtl/adc_pkg.sv
// Shared constants, state type and frame-field helper for the ADC serial front end.
package adc_pkg;

  localparam int unsigned FRAME_BITS  = 34;
  localparam int unsigned DATA_W      = 14;
  localparam int unsigned A_FIRST_BIT = 2;
  localparam int unsigned B_FIRST_BIT = 18;
  localparam int unsigned BIT_CNT_W   = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } adc_state_e;

  // True when frame bit index idx falls inside the 14-bit field starting at first.
  function automatic logic in_field(input logic [BIT_CNT_W-1:0] idx, input int unsigned first);
    return (idx >= BIT_CNT_W'(first)) && (idx < BIT_CNT_W'(first + DATA_W));
  endfunction

endpackage

// File: rtl/adc_sck_gen.sv
// SCK divider: low half first, then high half, each SCK_DIV clocks; idle low when disabled.
module adc_sck_gen #(
  parameter int unsigned SCK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic sck_o,
  output logic rise_tick_c,
  output logic period_end_c
);

  localparam int unsigned DIV_W = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;

  logic [DIV_W-1:0] div_q, div_d;
  logic             sck_q, sck_d;
  logic             half_end_c;

  assign half_end_c   = (div_q == DIV_W'(SCK_DIV - 1));
  assign rise_tick_c  = en_i && half_end_c && !sck_q;
  assign period_end_c = en_i && half_end_c && sck_q;
  assign sck_o        = sck_q;

  // Divider advance and SCK toggle at the end of each half period.
  always_comb begin
    div_d = div_q;
    sck_d = sck_q;
    if (!en_i) begin
      div_d = '0;
      sck_d = 1'b0;
    end else if (half_end_c) begin
      div_d = '0;
      sck_d = ~sck_q;
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  // Divider registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q <= '0;
      sck_q <= 1'b0;
    end else begin
      div_q <= div_d;
      sck_q <= sck_d;
    end
  end

endmodule

// File: rtl/adc_frame_reader.sv
// Frame sequencer for the dual-channel 14-bit serial ADC: conversion pulse, 34-bit shift, result strobe.
module adc_frame_reader
  import adc_pkg::*;
#(
  parameter int unsigned SCK_DIV     = 4,
  parameter int unsigned CONV_CYCLES = 4
) (
  input  logic              CLK50MHZ,
  input  logic              RST,
  input  logic              adc_trig,
  output logic              adc_done,
  output logic [DATA_W-1:0] adc_a,
  output logic [DATA_W-1:0] adc_b,
  output logic              busy,
  output logic              ad_conv,
  output logic              spi_sck,
  input  logic              adc_miso
);

  localparam int unsigned CONV_W = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;

  adc_state_e            state_q, state_d;
  logic [CONV_W-1:0]     conv_cnt_q, conv_cnt_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]     sh_a_q, sh_a_d, sh_b_q, sh_b_d;
  logic [DATA_W-1:0]     adc_a_q, adc_a_d, adc_b_q, adc_b_d;
  logic                  done_q, done_d, busy_q, busy_d, conv_q, conv_d;
  logic                  sck_en_c, rise_tick_c, period_end_c;
  logic                  conv_last_c, frame_last_c;

  assign sck_en_c     = (state_q == SHIFT);
  assign conv_last_c  = (conv_cnt_q == CONV_W'(CONV_CYCLES - 1));
  assign frame_last_c = period_end_c && (bit_cnt_q == BIT_CNT_W'(FRAME_BITS));

  adc_sck_gen #(.SCK_DIV(SCK_DIV)) u_sck_gen (
    .clk          (CLK50MHZ),
    .rst_n        (RST),
    .en_i         (sck_en_c),
    .sck_o        (spi_sck),
    .rise_tick_c  (rise_tick_c),
    .period_end_c (period_end_c)
  );

  // State register.
  always_ff @(posedge CLK50MHZ) begin
    if (!RST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state: triggers are only honoured in IDLE, so requests while busy are dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (adc_trig)     state_d = CONV;
      CONV:    if (conv_last_c)  state_d = SHIFT;
      SHIFT:   if (frame_last_c) state_d = DONE;
      DONE:                      state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  // Output and datapath next values; pins and strobes follow the upcoming state.
  always_comb begin
    conv_cnt_d = '0;
    bit_cnt_d  = '0;
    sh_a_d     = sh_a_q;
    sh_b_d     = sh_b_q;
    adc_a_d    = adc_a_q;
    adc_b_d    = adc_b_q;
    busy_d     = (state_d != IDLE);
    conv_d     = (state_d == CONV);
    done_d     = (state_d == DONE);
    if (state_q == CONV && !conv_last_c) begin
      conv_cnt_d = conv_cnt_q + 1'b1;
    end
    if (state_q == SHIFT) begin
      bit_cnt_d = bit_cnt_q;
      if (rise_tick_c) begin
        if (bit_cnt_q != BIT_CNT_W'(FRAME_BITS)) bit_cnt_d = bit_cnt_q + 1'b1;
        if (in_field(bit_cnt_q, A_FIRST_BIT)) sh_a_d = {sh_a_q[DATA_W-2:0], adc_miso};
        if (in_field(bit_cnt_q, B_FIRST_BIT)) sh_b_d = {sh_b_q[DATA_W-2:0], adc_miso};
      end
    end
    if (done_d) begin
      adc_a_d = sh_a_q;
      adc_b_d = sh_b_q;
    end
  end

  // Counters, shift registers and registered outputs.
  always_ff @(posedge CLK50MHZ) begin
    if (!RST) begin
      conv_cnt_q <= '0;
      bit_cnt_q  <= '0;
      sh_a_q     <= '0;
      sh_b_q     <= '0;
      adc_a_q    <= '0;
      adc_b_q    <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      conv_q     <= 1'b0;
    end else begin
      conv_cnt_q <= conv_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      sh_a_q     <= sh_a_d;
      sh_b_q     <= sh_b_d;
      adc_a_q    <= adc_a_d;
      adc_b_q    <= adc_b_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      conv_q     <= conv_d;
    end
  end

  assign adc_done = done_q;
  assign adc_a    = adc_a_q;
  assign adc_b    = adc_b_q;
  assign busy     = busy_q;
  assign ad_conv  = conv_q;

endmodule
